// File: rtl/if_id_fetch_stage.sv
// if_id_fetch_stage
//   Instruction-fetch stage with the IF/ID pipeline register of the 16-bit
//   pipelined datapath. Holds the PC and fetches over a req/valid handshake.
//   A one-entry hold buffer absorbs a response that lands while the hazard unit
//   stalls. A branch redirect aimed at an outstanding request is retired
//   through the DROP state, so the stale data never reaches IF/ID.
// Ports
//   clk, rst                 clock, async active-high reset
//   stall, if_flush          hazard-unit hold, control-unit squash of IF/ID
//   branch_taken/_target     fetch redirect from EX
//   imem_req/addr            fetch request (address stable until imem_valid)
//   imem_rdata/valid         fetch response (may be zero-wait)
//   if_id_instr/pc1/valid    IF/ID register outputs
module if_id_fetch_stage #(
    parameter int unsigned          ADDR_W    = 16,
    parameter int unsigned          INSTR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC  = 16'h0000,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                if_flush,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                imem_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc1,
    output logic                if_id_valid
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    drop_addr_q, drop_addr_d;
    logic [INSTR_W-1:0]   hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]    hold_pc1_q, hold_pc1_d;
    logic                 hold_vld_q, hold_vld_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    pc1_q, pc1_d;
    logic                 vld_q, vld_d;
    logic [ADDR_W-1:0]    pc_inc;

    // Wraps modulo 2^ADDR_W by truncation.
    assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    // Outputs depend on registered state only, never on stall/if_flush.
    assign imem_req    = (state_q == S_FETCH) || (state_q == S_DROP);
    assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc1   = pc1_q;
    assign if_id_valid = vld_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc1_d   = hold_pc1_q;
        hold_vld_d   = hold_vld_q;
        instr_d      = instr_q;
        pc1_d        = pc1_q;
        vld_d        = vld_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                if (branch_taken) pc_d = branch_target;
            end
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d = branch_target;
                    // No response yet: keep the old address up until it retires.
                    if (!imem_valid) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (imem_valid) begin
                    pc_d = pc_inc;
                    if (stall) begin
                        hold_instr_d = imem_rdata;
                        hold_pc1_d   = pc_inc;
                        hold_vld_d   = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        instr_d = imem_rdata;
                        pc1_d   = pc_inc;
                        vld_d   = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    hold_vld_d = 1'b0;
                    pc_d       = branch_target;
                    state_d    = S_FETCH;
                end else if (!stall) begin
                    // A flushed buffer releases as a bubble.
                    instr_d    = hold_instr_q;
                    pc1_d      = hold_pc1_q;
                    vld_d      = hold_vld_q;
                    hold_vld_d = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_DROP: begin
                if (branch_taken) pc_d = branch_target;
                if (imem_valid)   state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush beats every load path and empties the hold buffer; pc is untouched.
        if (if_flush) begin
            instr_d      = NOP_INSTR;
            pc1_d        = '0;
            vld_d        = 1'b0;
            hold_instr_d = NOP_INSTR;
            hold_pc1_d   = '0;
            hold_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc1_q   <= '0;
            hold_vld_q   <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc1_q        <= '0;
            vld_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc1_q   <= hold_pc1_d;
            hold_vld_q   <= hold_vld_d;
            instr_q      <= instr_d;
            pc1_q        <= pc1_d;
            vld_q        <= vld_d;
        end
    end
endmodule
